// File: rtl/common.sv
// Shared types for the vgacpu-to-raster-GPU command path.
package common;

  // Raster operations understood by the GPU; 0 is the idle/no-op encoding.
  typedef enum logic [2:0] {
    RC_NOP   = 3'd0,
    RC_CLEAR = 3'd1,
    RC_PIXEL = 3'd2,
    RC_LINE  = 3'd3,
    RC_RECT  = 3'd4,
    RC_FILL  = 3'd5
  } raster_command_t;

  // One complete queued command as handed to the GPU.
  typedef struct packed {
    raster_command_t command;
    logic [7:0]      x0;
    logic [7:0]      y0;
    logic [7:0]      x1;
    logic [7:0]      y1;
    logic [2:0]      colour;
  } gpu_cmd_t;

  localparam int GPU_CMD_W = $bits(gpu_cmd_t);

  // Dispatcher states.
  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_ISSUE = 2'd1,
    DISP_GUARD = 2'd2,
    DISP_WAIT  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO. The head is presented straight from storage and is
// valid whenever the FIFO is not empty. A push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Command buffer between the vgacpu core and the raster GPU. Commands are queued
// in a FIFO and dispatched one at a time; after each request the GPU's busy line
// is ignored for ISSUE_GUARD cycles to cover its rise latency.
module gpu_cmd_queue
  import common::*;
#(
  parameter int DEPTH       = 8,
  parameter int ISSUE_GUARD = 2
) (
  input  logic            clk,
  input  logic            rst_async,
  input  raster_command_t cpu_command,
  input  logic [7:0]      cpu_x0,
  input  logic [7:0]      cpu_y0,
  input  logic [7:0]      cpu_x1,
  input  logic [7:0]      cpu_y1,
  input  logic [2:0]      cpu_colour,
  input  logic            cpu_push,
  output logic            cpu_full,
  output logic            cpu_idle,
  output logic            overflow,
  output raster_command_t gpu_command,
  output logic [7:0]      gpu_x0,
  output logic [7:0]      gpu_y0,
  output logic [7:0]      gpu_x1,
  output logic [7:0]      gpu_y1,
  output logic [2:0]      gpu_colour,
  output logic            gpu_execute_request,
  input  logic            gpu_busy
);

  localparam int GW = (ISSUE_GUARD > 1) ? $clog2(ISSUE_GUARD) : 1;

  gpu_cmd_t    wr_entry;
  gpu_cmd_t    fifo_head;
  logic        fifo_full, fifo_empty, pop;

  disp_state_t state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  gpu_cmd_t    gpu_cmd_q, gpu_cmd_d;
  logic        req_q, req_d;
  logic        ovf_q, ovf_d;

  assign wr_entry = '{command: cpu_command, x0: cpu_x0, y0: cpu_y0,
                      x1: cpu_x1, y1: cpu_y1, colour: cpu_colour};

  sync_fifo #(
    .WIDTH(GPU_CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_async),
    .push  (cpu_push),
    .wdata (wr_entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Dispatcher: pop when idle, strobe the request, sit out the guard, wait for busy to drop.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    gpu_cmd_d = gpu_cmd_q;
    req_d     = 1'b0;
    pop       = 1'b0;
    case (state_q)
      DISP_IDLE: begin
        if (!fifo_empty && !gpu_busy) begin
          pop       = 1'b1;
          gpu_cmd_d = fifo_head;
          req_d     = 1'b1;
          state_d   = DISP_ISSUE;
        end
      end
      DISP_ISSUE: begin
        guard_d = GW'(ISSUE_GUARD - 1);
        state_d = DISP_GUARD;
      end
      DISP_GUARD: begin
        if (guard_q == '0) state_d = DISP_WAIT;
        else               guard_d = guard_q - GW'(1);
      end
      DISP_WAIT: begin
        if (!gpu_busy) state_d = DISP_IDLE;
      end
      default: state_d = DISP_IDLE;
    endcase
    // A push is lost only when the queue is full and nothing leaves this cycle.
    ovf_d = ovf_q | (cpu_push & fifo_full & ~pop);
  end

  // Dispatcher state and registered GPU-facing outputs.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state_q   <= DISP_IDLE;
      guard_q   <= '0;
      gpu_cmd_q <= '0;
      req_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      gpu_cmd_q <= gpu_cmd_d;
      req_q     <= req_d;
      ovf_q     <= ovf_d;
    end
  end

  assign cpu_full            = fifo_full;
  assign cpu_idle            = fifo_empty && (state_q == DISP_IDLE) && !gpu_busy;
  assign overflow            = ovf_q;
  assign gpu_execute_request = req_q;
  assign gpu_command         = gpu_cmd_q.command;
  assign gpu_x0              = gpu_cmd_q.x0;
  assign gpu_y0              = gpu_cmd_q.y0;
  assign gpu_x1              = gpu_cmd_q.x1;
  assign gpu_y1              = gpu_cmd_q.y1;
  assign gpu_colour          = gpu_cmd_q.colour;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Scoreboard bench for gpu_cmd_queue: accepted pushes are queued as expected
// commands; a monitor pops and compares on every gpu_execute_request.
module tb_gpu_cmd_queue;
  import common::*;

  localparam int DEPTH = 8;
  localparam int GUARD = 2;

  logic            clk = 1'b0;
  logic            rst_async = 1'b0;
  raster_command_t cpu_command = RC_NOP;
  logic [7:0]      cpu_x0 = '0, cpu_y0 = '0, cpu_x1 = '0, cpu_y1 = '0;
  logic [2:0]      cpu_colour = '0;
  logic            cpu_push = 1'b0;
  logic            cpu_full, cpu_idle, overflow;
  raster_command_t gpu_command;
  logic [7:0]      gpu_x0, gpu_y0, gpu_x1, gpu_y1;
  logic [2:0]      gpu_colour;
  logic            gpu_execute_request;
  logic            gpu_busy = 1'b0;

  gpu_cmd_queue #(.DEPTH(DEPTH), .ISSUE_GUARD(GUARD)) dut (
    .clk(clk), .rst_async(rst_async),
    .cpu_command(cpu_command), .cpu_x0(cpu_x0), .cpu_y0(cpu_y0),
    .cpu_x1(cpu_x1), .cpu_y1(cpu_y1), .cpu_colour(cpu_colour), .cpu_push(cpu_push),
    .cpu_full(cpu_full), .cpu_idle(cpu_idle), .overflow(overflow),
    .gpu_command(gpu_command), .gpu_x0(gpu_x0), .gpu_y0(gpu_y0),
    .gpu_x1(gpu_x1), .gpu_y1(gpu_y1), .gpu_colour(gpu_colour),
    .gpu_execute_request(gpu_execute_request), .gpu_busy(gpu_busy)
  );

  always #10 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  gpu_cmd_t exp_q[$];
  bit  ovf_exp = 0;
  int  cyc = 0, last_req = -100, req_count = 0;
  bit  p_push = 0;
  gpu_cmd_t p_data;
  // GPU model controls
  bit  hold_busy = 0, rand_busy = 0;
  int  busy_delay = 1, busy_len = 3, rise_cnt = 0, busy_cnt = 0, cur_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Capture what the DUT samples at each rising edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    p_push <= cpu_push & rst_async;
    p_data <= '{command: cpu_command, x0: cpu_x0, y0: cpu_y0, x1: cpu_x1, y1: cpu_y1, colour: cpu_colour};
  end

  // Monitor + reference FIFO + GPU busy model, evaluated between edges.
  always @(negedge clk) begin
    logic [63:0] got;
    gpu_cmd_t e;
    if (!rst_async) begin
      exp_q.delete();
      ovf_exp  = 0;
      rise_cnt = 0;
      busy_cnt = 0;
      gpu_busy = 1'b0;
      last_req = -100;
    end else begin
      if (gpu_execute_request) begin
        req_count++;
        check("req_while_gpu_busy", {62'd0, gpu_busy, (rise_cnt > 0)}, 64'd0);
        check("req_spacing_ok", 64'(cyc - last_req >= 3 + GUARD), 64'd1);
        last_req = cyc;
        got = 64'({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour});
        if (exp_q.size() == 0) begin
          check("spurious_req", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("req_data", got, 64'(e));
        end
        // GPU accepts the command and will go busy after its rise latency.
        rise_cnt = rand_busy ? $urandom_range(1, GUARD) : busy_delay;
        cur_len  = rand_busy ? $urandom_range(1, 25) : busy_len;
      end
      if (p_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(p_data);
        else ovf_exp = 1;
      end
      check("cpu_full", 64'(cpu_full), 64'(exp_q.size() == DEPTH));
      check("overflow", 64'(overflow), 64'(ovf_exp));
      if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) busy_cnt = cur_len;
      end
      gpu_busy = hold_busy || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_cmd(input gpu_cmd_t c);
    cpu_command = c.command; cpu_x0 = c.x0; cpu_y0 = c.y0;
    cpu_x1 = c.x1; cpu_y1 = c.y1; cpu_colour = c.colour;
    cpu_push = 1'b1;
    tick();
    cpu_push = 1'b0;
  endtask

  function automatic gpu_cmd_t rand_cmd();
    gpu_cmd_t c;
    c.command = raster_command_t'($urandom_range(0, 5));
    c.x0 = 8'($urandom); c.y0 = 8'($urandom);
    c.x1 = 8'($urandom); c.y1 = 8'($urandom);
    c.colour = 3'($urandom);
    return c;
  endfunction

  // Wait (bounded) until everything is delivered and the GPU is quiet, then expect cpu_idle.
  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_q.size() == 0 && !gpu_busy && rise_cnt == 0 && busy_cnt == 0) done = 1;
      else tick();
    end
    if (!done) check({name, "_drain_timeout"}, 64'd0, 64'd1);
    repeat (4) tick();
    check({name, "_cpu_idle"}, 64'(cpu_idle), 64'd1);
  endtask

  initial begin
    gpu_cmd_t c;
    int k, seen_cyc, r0;
    // Reset state
    repeat (2) tick();
    check("rst_req", 64'(gpu_execute_request), 64'd0);
    check("rst_full", 64'(cpu_full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_gpu_fields", 64'({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour}), 64'd0);
    rst_async = 1'b1;
    repeat (2) tick();
    check("rst_idle", 64'(cpu_idle), 64'd1);

    // 1: single FILL, latency and pulse width
    busy_delay = 1; busy_len = 4;
    c = '{command: RC_FILL, x0: 8'd1, y0: 8'd2, x1: 8'd30, y1: 8'd40, colour: 3'b101};
    k = cyc;
    push_cmd(c);
    check("t1_idle_after_push", 64'(cpu_idle), 64'd0);
    seen_cyc = -1;
    for (int i = 0; i < 10 && seen_cyc < 0; i++) begin
      if (gpu_execute_request) seen_cyc = cyc;
      else tick();
    end
    check("t1_latency", 64'(seen_cyc - k), 64'd2);
    check("t1_colour", 64'(gpu_colour), 64'd5);
    tick();
    check("t1_req_width", 64'(gpu_execute_request), 64'd0);
    wait_drain("t1");

    // 2: burst of 8 LINE commands, GPU busy 20 cycles each
    busy_delay = 1; busy_len = 20; hold_busy = 1; r0 = req_count;
    for (int i = 0; i < 8; i++)
      push_cmd('{command: RC_LINE, x0: 8'(i), y0: 8'(2*i), x1: 8'(100+i), y1: 8'(200-i), colour: 3'(i)});
    check("t2_full", 64'(cpu_full), 64'd1);
    hold_busy = 0;
    wait_drain("t2");
    check("t2_req_count", 64'(req_count - r0), 64'd8);
    check("t2_ovf", 64'(overflow), 64'd0);

    // 4: push on the same cycle as a pop from a full queue
    hold_busy = 1; r0 = req_count;
    for (int i = 0; i < 8; i++) push_cmd(rand_cmd());
    check("t4_full_before", 64'(cpu_full), 64'd1);
    hold_busy = 0;
    tick();
    push_cmd(rand_cmd());
    check("t4_pop_seen", 64'(gpu_execute_request), 64'd1);
    check("t4_full_after", 64'(cpu_full), 64'd1);
    check("t4_ovf", 64'(overflow), 64'd0);
    wait_drain("t4");
    check("t4_req_count", 64'(req_count - r0), 64'd9);

    // 3: overflow
    hold_busy = 1; r0 = req_count;
    for (int i = 0; i < 9; i++) push_cmd(rand_cmd());
    check("t3_ovf_set", 64'(overflow), 64'd1);
    hold_busy = 0;
    wait_drain("t3");
    check("t3_req_count", 64'(req_count - r0), 64'd8);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 5: GPU raises busy two cycles after each request
    busy_delay = 2; busy_len = 6; r0 = req_count;
    for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
    wait_drain("t5");
    check("t5_req_count", 64'(req_count - r0), 64'd3);

    // 6: reset during WAIT with three entries queued
    busy_delay = 1; busy_len = 30; r0 = req_count;
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
    for (int i = 0; i < 20 && req_count == r0; i++) tick();
    check("t6_first_req", 64'(req_count - r0), 64'd1);
    repeat (4) tick();
    rst_async = 1'b0;
    #1;
    check("t6_rst_req", 64'(gpu_execute_request), 64'd0);
    check("t6_rst_full", 64'(cpu_full), 64'd0);
    check("t6_rst_ovf", 64'(overflow), 64'd0);
    check("t6_rst_fields", 64'({gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour}), 64'd0);
    repeat (2) tick();
    rst_async = 1'b1;
    r0 = req_count;
    repeat (20) tick();
    check("t6_no_req_after_rst", 64'(req_count - r0), 64'd0);
    check("t6_idle", 64'(cpu_idle), 64'd1);
    busy_len = 3;
    push_cmd(rand_cmd());
    wait_drain("t6");
    check("t6_req_after_push", 64'(req_count - r0), 64'd1);

    // 7: randomized traffic with random GPU latency and busy length
    rand_busy = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 40) push_cmd(rand_cmd());
      else tick();
    end
    rand_busy = 0;
    wait_drain("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
